mem_copy_dma: RTL

Block-copy engine that is the initiator side of the dual-port main memory: it reads a run of 18-bit words through port A and writes them through port B, one word per cycle. It sits between the CPU's control registers and the main memory port pair and gives software a hardware memmove over the 11-bank, 11264-word address space. Overlapping ranges are copied in the safe direction.

---
 rtl/mem_copy_dma_pkg.sv | 8 +
 rtl/mem_copy_dma_if.sv | 17 +
 rtl/mem_copy_dma_agu.sv | 44 ++++
 rtl/mem_copy_dma.sv | 99 +++++++++
 4 files changed

// File: rtl/mem_copy_dma_pkg.sv
// Shared constants and state encoding for the main-memory port pair and its initiators.
package mem_copy_dma_pkg;
   localparam int DATA      = 18;
   localparam int ADDR      = 14;
   localparam int MEM_WORDS = 11264;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/mem_copy_dma_if.sv
// Dual-port main memory bus: port A is the read side, port B is the write side.
interface mem_copy_dma_if #(
   parameter int DATA = mem_copy_dma_pkg::DATA,
   parameter int ADDR = mem_copy_dma_pkg::ADDR
);
   logic            wea;
   logic [DATA-1:0] dina;
   logic [ADDR-1:0] addra;
   logic [DATA-1:0] douta;
   logic            web;
   logic [ADDR-1:0] addrb;
   logic [DATA-1:0] dinb;
   logic [DATA-1:0] doutb;

   modport master (output wea, dina, addra, web, addrb, dinb, input douta, doutb);
   modport slave  (input wea, dina, addra, web, addrb, dinb, output douta, doutb);
endinterface

// File: rtl/mem_copy_dma_agu.sv
// Range check, copy direction and read-offset counter for the block copy engine.
module mem_copy_dma_agu #(
   parameter int ADDR      = mem_copy_dma_pkg::ADDR,
   parameter int MEM_WORDS = mem_copy_dma_pkg::MEM_WORDS
) (
   input  logic            clka,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic [ADDR-1:0] src,
   input  logic [ADDR-1:0] dst,
   input  logic [ADDR-1:0] len,
   output logic [ADDR-1:0] off,
   output logic            last,
   output logic            bwd,
   output logic            range_err
);
   logic [ADDR:0]   src_end;
   logic [ADDR:0]   dst_end;
   logic            bwd_n;
   logic [ADDR-1:0] rem;

   assign src_end   = {1'b0, src} + {1'b0, len};
   assign dst_end   = {1'b0, dst} + {1'b0, len};
   assign range_err = (src_end > (ADDR+1)'(MEM_WORDS)) || (dst_end > (ADDR+1)'(MEM_WORDS));
   // Destination starting inside the source run must be filled from the top down.
   assign bwd_n     = (dst > src) && ({1'b0, dst} < src_end);
   assign last      = (rem == ADDR'(1));

   always_ff @(posedge clka) begin
      if (rst) begin
         off <= '0;
         rem <= '0;
         bwd <= 1'b0;
      end else if (load) begin
         bwd <= bwd_n;
         off <= bwd_n ? len - ADDR'(1) : '0;
         rem <= len;
      end else if (step) begin
         off <= bwd ? off - ADDR'(1) : off + ADDR'(1);
         rem <= rem - ADDR'(1);
      end
   end
endmodule

// File: rtl/mem_copy_dma.sv
// Hardware memmove over main memory: reads through port A, writes one cycle later through port B.
//  state | meaning
//  IDLE  | waiting for start; latches request and checks range
//  RUN   | issuing one read per cycle
//  DRAIN | last read in flight; final write goes out
//  DONE  | one-cycle completion, done pulse follows
module mem_copy_dma #(
   parameter int DATA      = mem_copy_dma_pkg::DATA,
   parameter int ADDR      = mem_copy_dma_pkg::ADDR,
   parameter int MEM_WORDS = mem_copy_dma_pkg::MEM_WORDS
) (
   input  logic            clka,
   input  logic            rst,
   input  logic            start,
   input  logic [ADDR-1:0] src,
   input  logic [ADDR-1:0] dst,
   input  logic [ADDR-1:0] len,
   output logic            busy,
   output logic            done,
   output logic            err,
   mem_copy_dma_if.master  mem
);
   import mem_copy_dma_pkg::*;

   state_t          state;
   logic [ADDR-1:0] src_q, dst_q, off, poff, addra_q, addrb_q;
   logic            pv, web_q, bad_q, last, bwd, range_err, load, step;
   logic            unused_sig;

   assign load = (state == IDLE) && start;
   assign step = (state == RUN);

   mem_copy_dma_agu #(.ADDR(ADDR), .MEM_WORDS(MEM_WORDS)) u_agu (
      .clka(clka), .rst(rst), .load(load), .step(step),
      .src(src), .dst(dst), .len(len),
      .off(off), .last(last), .bwd(bwd), .range_err(range_err)
   );

   assign mem.wea   = 1'b0;
   assign mem.dina  = '0;
   assign mem.addra = addra_q;
   assign mem.web   = web_q;
   assign mem.addrb = addrb_q;
   // Read data arrives in the same cycle the write is presented, so it passes straight through.
   assign mem.dinb  = web_q ? mem.douta : '0;
   assign unused_sig = ^{mem.doutb, bwd};

   always_ff @(posedge clka) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         bad_q   <= 1'b0;
         web_q   <= 1'b0;
         pv      <= 1'b0;
         poff    <= '0;
         addra_q <= '0;
         addrb_q <= '0;
         src_q   <= '0;
         dst_q   <= '0;
      end else begin
         done  <= 1'b0;
         web_q <= pv;
         pv    <= 1'b0;
         if (pv) addrb_q <= dst_q + poff;
         case (state)
            IDLE: begin
               if (start) begin
                  src_q <= src;
                  dst_q <= dst;
                  err   <= 1'b0;
                  bad_q <= range_err;
                  if (range_err || len == '0) begin
                     state <= DONE;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               addra_q <= src_q + off;
               poff    <= off;
               pv      <= 1'b1;
               if (last) state <= DRAIN;
            end
            DRAIN: state <= DONE;
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               err   <= bad_q;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
